// File: rtl/sync_train_pkg.sv
// Shared definitions for the sync pulse-train controller: state encoding and
// default widths used by the controller and its timing counter.
package sync_train_pkg;

  localparam int DEF_CNT_BITS = 16;
  localparam int DEF_NUM_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } sync_state_e;

endpackage

// File: rtl/sync_down_counter.sv
// Loadable down-counter used to time the delay, pulse-low and gap phases.
// A phase lasting N cycles is loaded with N-1; the zero flag marks its last cycle.
module sync_down_counter
  import sync_train_pkg::*;
#(
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [CNT_BITS-1:0] cnt;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_BITS'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sync_train_ctrl.sv
// Active-low sync pulse-train generator: after an accepted start edge it waits
// cfg_delay cycles, then emits cfg_num low pulses of cfg_width cycles spaced
// cfg_period cycles apart (falling edge to falling edge).
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | waiting for a start edge, sync_out high
//   ST_DELAY | counting the delay before the first pulse
//   ST_PULSE | sync_out low for the latched width
//   ST_GAP   | sync_out high for the remainder of the period
module sync_train_ctrl
  import sync_train_pkg::*;
#(
  parameter int CNT_BITS = DEF_CNT_BITS,
  parameter int NUM_BITS = DEF_NUM_BITS
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_BITS-1:0] cfg_delay,
  input  logic [CNT_BITS-1:0] cfg_width,
  input  logic [CNT_BITS-1:0] cfg_period,
  input  logic [NUM_BITS-1:0] cfg_num,
  output logic                sync_out,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                cfg_err,
  output logic [NUM_BITS-1:0] pulse_cnt
);

  sync_state_e         state, state_nxt;
  logic                start_q;
  logic [CNT_BITS-1:0] width_q, period_q;
  logic [NUM_BITS-1:0] num_q;

  logic                start_edge, cfg_bad;
  logic [CNT_BITS-1:0] gap_m1;
  logic [NUM_BITS-1:0] pc_plus1;

  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CNT_BITS-1:0] cnt_val;
  logic                latch_cfg, pc_clr, pc_inc;
  logic                done_nxt, aborted_nxt, err_nxt;

  assign start_edge = start && !start_q;
  assign cfg_bad    = (cfg_num == '0) || (cfg_width == '0) || (cfg_period <= cfg_width);
  // Period is strictly greater than width once accepted, so this never underflows.
  assign gap_m1     = period_q - width_q - CNT_BITS'(1);
  assign pc_plus1   = pulse_cnt + NUM_BITS'(1);
  assign busy       = (state != ST_IDLE);

  sync_down_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, timer control and strobe decisions; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt   = state;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    latch_cfg   = 1'b0;
    pc_clr      = 1'b0;
    pc_inc      = 1'b0;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_edge && !abort) begin
          if (cfg_bad) begin
            err_nxt = 1'b1;
          end else begin
            latch_cfg = 1'b1;
            pc_clr    = 1'b1;
            cnt_load  = 1'b1;
            if (cfg_delay == '0) begin
              state_nxt = ST_PULSE;
              cnt_val   = cfg_width - CNT_BITS'(1);
            end else begin
              state_nxt = ST_DELAY;
              cnt_val   = cfg_delay - CNT_BITS'(1);
            end
          end
        end
      end
      ST_DELAY, ST_GAP: begin
        if (cnt_zero) begin
          state_nxt = ST_PULSE;
          cnt_load  = 1'b1;
          cnt_val   = width_q - CNT_BITS'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          pc_inc = 1'b1;
          if (pc_plus1 == num_q) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_GAP;
            cnt_load  = 1'b1;
            cnt_val   = gap_m1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A pulse cut short by abort does not count as completed.
    if ((state != ST_IDLE) && abort) begin
      state_nxt   = ST_IDLE;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      pc_inc      = 1'b0;
      done_nxt    = 1'b1;
      aborted_nxt = 1'b1;
    end
  end

  // State, edge detector, latched configuration and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      start_q   <= 1'b1;
      width_q   <= '0;
      period_q  <= '0;
      num_q     <= '0;
      sync_out  <= 1'b1;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cfg_err   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state    <= state_nxt;
      start_q  <= start;
      sync_out <= (state_nxt != ST_PULSE);
      done     <= done_nxt;
      aborted  <= aborted_nxt;
      cfg_err  <= err_nxt;
      if (latch_cfg) begin
        width_q  <= cfg_width;
        period_q <= cfg_period;
        num_q    <= cfg_num;
      end
      if (pc_clr) begin
        pulse_cnt <= '0;
      end else if (pc_inc) begin
        pulse_cnt <= pc_plus1;
      end
    end
  end

endmodule

// File: tb/tb_sync_train_ctrl.sv
// Self-checking bench for sync_train_ctrl. Expected outputs come from a
// closed-form model of the pulse train (arithmetic on delay/width/period/num
// relative to the start-edge cycle), compared every cycle at the falling edge.
module tb_sync_train_ctrl;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_width;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_num;
  logic        sync_out;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        cfg_err;
  logic [7:0]  pulse_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  last_pc = 8'd0;

  sync_train_ctrl #(
    .CNT_BITS (16),
    .NUM_BITS (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_period (cfg_period),
    .cfg_num    (cfg_num),
    .sync_out   (sync_out),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .cfg_err    (cfg_err),
    .pulse_cnt  (pulse_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {cfg_err, sync_out, busy, done, aborted, pulse_cnt} in cycle k after
  // a start edge in cycle 0; ka is the cycle abort is held high (-1 for none).
  function automatic logic [12:0] model(int d, int w, int p, int n, int ka, int k);
    int end_k;
    int lim;
    int pc;
    int j;
    bit low;
    end_k = 1 + d + (n - 1) * p + w;
    lim   = (ka >= 0 && k > ka) ? ka : k;
    pc    = 0;
    for (int i = 0; i < n; i++) begin
      if (1 + d + i * p + w <= lim) pc++;
    end
    if (ka >= 0 && k > ka)
      return {1'b0, 1'b1, 1'b0, (k == ka + 1), (k == ka + 1), 8'(pc)};
    if (k >= end_k)
      return {1'b0, 1'b1, 1'b0, (k == end_k), 1'b0, 8'(pc)};
    j   = k - 1 - d;
    low = (j >= 0) && (j / p < n) && (j % p < w);
    return {1'b0, !low, 1'b1, 1'b0, 1'b0, 8'(pc)};
  endfunction

  // One train: start edge (unless the previous train already raised it on its
  // done cycle), optional abort, optional cfg scrambling, optional extra start
  // edge while busy, optional re-trigger on the done cycle.
  task automatic run_train(input int d, input int w, input int p, input int n, input int ka,
                           input bit scramble, input bit poke, input bit chain, input bit pre);
    int          stop;
    int          last_k;
    bit          do_poke;
    logic [12:0] exp_v;
    logic [12:0] act;
    stop    = (ka >= 0) ? ka + 1 : 1 + d + (n - 1) * p + w;
    do_poke = poke && (stop > 3);
    last_k  = chain ? stop : stop + 1;
    if (!pre) begin
      @(negedge clock);
      cfg_delay  = 16'(d);
      cfg_width  = 16'(w);
      cfg_period = 16'(p);
      cfg_num    = 8'(n);
      abort      = 1'b0;
      start      = 1'b1;
    end
    exp_v = '0;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clock);
      exp_v = model(d, w, p, n, ka, k);
      act   = {cfg_err, sync_out, busy, done, aborted, pulse_cnt};
      n_vec++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL train d=%0d w=%0d p=%0d n=%0d ka=%0d k=%0d: got err/sync/busy/done/abt/cnt=%b required %b",
                 d, w, p, n, ka, k, act, exp_v);
      end
      start = do_poke && (k == 2);
      abort = (k == ka);
      if (scramble && k < stop) begin
        cfg_delay  = 16'($urandom);
        cfg_width  = 16'($urandom);
        cfg_period = 16'($urandom);
        cfg_num    = 8'($urandom);
      end
      if (chain && k == stop) begin
        cfg_delay  = 16'(d);
        cfg_width  = 16'(w);
        cfg_period = 16'(p);
        cfg_num    = 8'(n);
        start      = 1'b1;
      end
    end
    last_pc = exp_v[7:0];
  endtask

  task automatic test_reset();
    logic [12:0] act;
    reset_n    = 1'b0;
    start      = 1'b1;
    abort      = 1'b0;
    cfg_delay  = 16'd1;
    cfg_width  = 16'd2;
    cfg_period = 16'd4;
    cfg_num    = 8'd2;
    repeat (2) @(negedge clock);
    act = {cfg_err, sync_out, busy, done, aborted, pulse_cnt};
    n_vec++;
    if (act !== 13'b0_1_0_0_0_00000000) begin
      n_err++;
      $display("FAIL reset_values: got %b required %b", act, 13'b0_1_0_0_0_00000000);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      act = {cfg_err, sync_out, busy, done, aborted, pulse_cnt};
      n_vec++;
      if (act !== 13'b0_1_0_0_0_00000000) begin
        n_err++;
        $display("FAIL start_held_through_reset k=%0d: got %b required %b", k, act, 13'b0_1_0_0_0_00000000);
      end
    end
    start = 1'b0;
    @(negedge clock);
    last_pc = 8'd0;
  endtask

  task automatic test_reject();
    logic [12:0] act;
    logic [12:0] exp_v;
    logic [15:0] bw [3];
    logic [15:0] bp [3];
    logic [7:0]  bn [3];
    bw = '{16'd4, 16'd0, 16'd2};
    bp = '{16'd4, 16'd5, 16'd5};
    bn = '{8'd3,  8'd3,  8'd0};
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      cfg_delay  = 16'd2;
      cfg_width  = bw[t];
      cfg_period = bp[t];
      cfg_num    = bn[t];
      start      = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clock);
        exp_v = {(k == 1), 1'b1, 1'b0, 1'b0, 1'b0, last_pc};
        act   = {cfg_err, sync_out, busy, done, aborted, pulse_cnt};
        n_vec++;
        if (act !== exp_v) begin
          n_err++;
          $display("FAIL reject case=%0d k=%0d: got %b required %b", t, k, act, exp_v);
        end
        start = 1'b0;
      end
    end
  endtask

  task automatic test_abort_priority();
    logic [12:0] act;
    logic [12:0] exp_v;
    for (int t = 0; t < 2; t++) begin
      @(negedge clock);
      cfg_delay  = 16'd0;
      cfg_width  = 16'd2;
      cfg_period = (t == 0) ? 16'd5 : 16'd1;
      cfg_num    = 8'd2;
      start      = 1'b1;
      abort      = 1'b1;
      for (int k = 1; k <= 2; k++) begin
        @(negedge clock);
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, last_pc};
        act   = {cfg_err, sync_out, busy, done, aborted, pulse_cnt};
        n_vec++;
        if (act !== exp_v) begin
          n_err++;
          $display("FAIL abort_over_start case=%0d k=%0d: got %b required %b", t, k, act, exp_v);
        end
        start = 1'b0;
        abort = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_train();
    logic [12:0] act;
    @(negedge clock);
    cfg_delay  = 16'd1;
    cfg_width  = 16'd3;
    cfg_period = 16'd6;
    cfg_num    = 8'd4;
    start      = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k >= 7) begin
        act = {cfg_err, sync_out, busy, done, aborted, pulse_cnt};
        n_vec++;
        if (act !== 13'b0_1_0_0_0_00000000) begin
          n_err++;
          $display("FAIL reset_mid_train k=%0d: got %b required %b", k, act, 13'b0_1_0_0_0_00000000);
        end
      end
      reset_n = (k == 6) ? 1'b0 : 1'b1;
    end
    last_pc = 8'd0;
  endtask

  task automatic test_spec_train();
    run_train(3, 2, 5, 3, -1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_min_train();
    run_train(0, 1, 2, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    // abort in the first low cycle of the third pulse: 1 + delay + 2*period
    run_train(2, 2, 5, 10, 13, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_train(1, 3, 6, 3, -1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_train(2, 2, 4, 3, -1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_train(2, 2, 4, 3, -1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int d, w, p, n, ka, end_k;
    bit pre, chain, scr, poke;
    pre = 1'b0;
    d = 0; w = 1; p = 2; n = 1;
    for (int it = 0; it < 40; it++) begin
      if (!pre) begin
        d = $urandom_range(0, 6);
        w = $urandom_range(1, 4);
        p = w + $urandom_range(1, 4);
        n = $urandom_range(1, 5);
      end
      end_k = 1 + d + (n - 1) * p + w;
      ka    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, end_k - 1) : -1;
      scr   = 1'($urandom_range(0, 1));
      poke  = 1'($urandom_range(0, 1));
      chain = (it == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      run_train(d, w, p, n, ka, scr, poke, chain, pre);
      pre = chain;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_delay  = '0;
    cfg_width  = '0;
    cfg_period = '0;
    cfg_num    = '0;
    test_reset();
    test_spec_train();
    test_min_train();
    test_reject();
    test_abort();
    test_reject();
    test_start_while_busy();
    test_back_to_back();
    test_abort_priority();
    test_reset_mid_train();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
